// File: rtl/holder_bank_pkg.sv
// rtl/holder_bank_pkg.sv - shared types and round-robin pick function for the holder bank arbiter
package holder_bank_pkg;

    localparam int RR_MAX_SRC = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } rr_pick_t;

    // First set request scanning last+1, last+2, ... modulo n; valid=0 when nothing is requested.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                         input logic [31:0] last,
                                         input int unsigned n);
        rr_pick_t    r;
        int unsigned c;
        r = '0;
        for (int unsigned k = 1; k <= RR_MAX_SRC; k++) begin
            if (k <= n && !r.valid) begin
                c = (last + k) % n;
                if (((req >> c) & 32'd1) != 32'd0) begin
                    r.valid = 1'b1;
                    r.idx   = c;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/slot_holder.sv
// rtl/slot_holder.sv - one holding register of the bank, cleared on reset, loaded on load_en
module slot_holder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Capture the source word when this slot is the one being loaded; otherwise retain.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (load_en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/holder_bank_arbiter.sv
// rtl/holder_bank_arbiter.sv - round-robin grant of a holding-register bank with valid/ready output
module holder_bank_arbiter
    import holder_bank_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       req,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    output logic [NUM_SRC-1:0]       gnt,
    output logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic               out_valid_q, out_valid_d;
    rr_pick_t           pick;
    logic [NUM_SRC-1:0] load_en;
    logic [WIDTH-1:0]   holder_q [NUM_SRC];

    // Holding bank: each slot captures its own source word only while it is the granted slot in LOAD.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        assign load_en[i] = (state_q == LOAD) && (sel_q == SEL_W'(i));
        slot_holder #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_en (load_en[i]),
            .d       (in_data[i*WIDTH +: WIDTH]),
            .q       (holder_q[i])
        );
    end

    // State, select, pointer, grant and valid registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= SEL_W'(NUM_SRC - 1);
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic: pick in IDLE, commit capture in LOAD, hold the word in PRESENT until consumed.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        gnt_d       = '0;
        out_valid_d = out_valid_q;
        pick        = rr_pick(RR_MAX_SRC'(req), 32'(last_q), NUM_SRC);
        case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    sel_d                   = SEL_W'(pick.idx);
                    gnt_d[SEL_W'(pick.idx)] = 1'b1;
                    state_d                 = LOAD;
                end
            end
            LOAD: begin
                out_valid_d = 1'b1;
                last_d      = sel_q;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out       = holder_q[sel_q];
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule
